// File: rtl/neuron_pkg.sv
// Shared definitions for the Izhikevich population datapath: sizes, fixed-point
// current type, synapse-driver FSM states and the symmetric saturation helper.
package neuron_pkg;

    localparam int unsigned NUM_NEURONS = 128;
    localparam int unsigned IDX_W       = 7;
    localparam int unsigned FRAC_BITS   = 10;
    localparam int          I_MAX       = 102400;

    typedef logic signed [31:0] cur_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StUpdate,
        StDone
    } syn_state_e;

    // Clamp a 33-bit intermediate to [-lim, +lim] before narrowing to 32 bits.
    function automatic cur_t sat_cur(input logic signed [32:0] x, input int lim);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = 33'(lim);
        lo = -hi;
        if (x > hi) begin
            return hi[31:0];
        end
        if (x < lo) begin
            return lo[31:0];
        end
        return x[31:0];
    endfunction

endpackage

// File: rtl/syn_update.sv
// One synapse step: exponential decay by an arithmetic shift, optional weight
// injection on a spike, then symmetric saturation. Purely combinational.
module syn_update #(
    parameter int unsigned TAU_SHIFT = 3,
    parameter int          I_MAX     = neuron_pkg::I_MAX
) (
    input  logic signed [31:0] s_i,
    input  logic               spike_i,
    input  logic signed [31:0] weight_i,
    output logic signed [31:0] s_new_o
);
    import neuron_pkg::*;

    cur_t               d;
    cur_t               s_dec;
    logic signed [32:0] sum;

    always_comb begin
        d     = s_i >>> TAU_SHIFT;
        // Zeroing once the decrement vanishes stops small positives stalling at 1..7.
        s_dec = (d == '0) ? '0 : s_i - d;
        sum   = $signed({s_dec[31], s_dec})
              + (spike_i ? $signed({weight_i[31], weight_i}) : 33'sd0);
        s_new_o = sat_cur(sum, I_MAX);
    end

endmodule

// File: rtl/pop_synapse_driver.sv
// Spike-to-current converter: sweeps 128 decaying synaptic currents per frame and
// streams (index, current) pairs at one entry every two cycles.
module pop_synapse_driver #(
    parameter int unsigned TAU_SHIFT = 3,
    parameter int          I_MAX     = neuron_pkg::I_MAX,
    parameter int          I_BIAS    = 0
) (
    input  logic               clk,
    input  logic               reset_bar,
    input  logic [127:0]       population,
    input  logic               pop_valid,
    input  logic signed [31:0] weight,
    output logic signed [31:0] I_out,
    output logic [6:0]         I_index,
    output logic               I_valid,
    output logic               sweep_done,
    output logic               busy,
    output logic               overrun
);
    import neuron_pkg::*;

    localparam logic signed [32:0] BIAS33 = 33'(I_BIAS);

    syn_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       shadow_q, shadow_d;
    cur_t               wgt_q, wgt_d;
    logic               pend_q, pend_d;
    logic [127:0]       pend_vec_q, pend_vec_d;
    cur_t               pend_wgt_q, pend_wgt_d;
    logic               overrun_q, overrun_d;
    cur_t               i_out_q, i_out_d;
    logic [IDX_W-1:0]   i_index_q, i_index_d;
    logic               i_valid_q, i_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               syn_we;
    cur_t               s_new;
    cur_t               syn_q [NUM_NEURONS];

    syn_update #(
        .TAU_SHIFT (TAU_SHIFT),
        .I_MAX     (I_MAX)
    ) u_syn_update (
        .s_i      (syn_q[idx_q]),
        .spike_i  (shadow_q[idx_q]),
        .weight_i (wgt_q),
        .s_new_o  (s_new)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        wgt_d      = wgt_q;
        pend_d     = pend_q;
        pend_vec_d = pend_vec_q;
        pend_wgt_d = pend_wgt_q;
        overrun_d  = overrun_q;
        i_out_d    = i_out_q;
        i_index_d  = i_index_q;
        i_valid_d  = 1'b0;
        done_d     = 1'b0;
        syn_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pop_valid) begin
                    shadow_d = population;
                    wgt_d    = weight;
                    idx_d    = '0;
                    state_d  = StRead;
                end
            end
            // The update is registered on the READ->UPDATE edge so the strobe is
            // visible during the UPDATE cycle.
            StRead: begin
                syn_we    = 1'b1;
                i_out_d   = sat_cur($signed({s_new[31], s_new}) + BIAS33, I_MAX);
                i_index_d = idx_q;
                i_valid_d = 1'b1;
                state_d   = StUpdate;
            end
            StUpdate: begin
                if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRead;
                end
            end
            StDone: begin
                if (pend_q) begin
                    shadow_d = pend_vec_q;
                    wgt_d    = pend_wgt_q;
                    pend_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = StRead;
                end else if (pop_valid) begin
                    shadow_d = population;
                    wgt_d    = weight;
                    idx_d    = '0;
                    state_d  = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frames arriving mid-sweep go to the one-deep pending buffer.
        if (pop_valid && state_q != StIdle && !(state_q == StDone && !pend_q)) begin
            pend_vec_d = population;
            pend_wgt_d = weight;
            pend_d     = 1'b1;
            if (pend_q && state_q != StDone) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            shadow_q   <= '0;
            wgt_q      <= '0;
            pend_q     <= 1'b0;
            pend_vec_q <= '0;
            pend_wgt_q <= '0;
            overrun_q  <= 1'b0;
            i_out_q    <= '0;
            i_index_q  <= '0;
            i_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            wgt_q      <= wgt_d;
            pend_q     <= pend_d;
            pend_vec_q <= pend_vec_d;
            pend_wgt_q <= pend_wgt_d;
            overrun_q  <= overrun_d;
            i_out_q    <= i_out_d;
            i_index_q  <= i_index_d;
            i_valid_q  <= i_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                syn_q[i] <= '0;
            end
        end else if (syn_we) begin
            syn_q[idx_q] <= s_new;
        end
    end

    assign I_out      = i_out_q;
    assign I_index    = i_index_q;
    assign I_valid    = i_valid_q;
    assign sweep_done = done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/pop_synapse_driver.md
Name: pop_synapse_driver

Overview:
- Spike-to-current converter for a 128-neuron time-multiplexed Izhikevich population.
- Consumes the 128-bit population spike vector one frame at a time.
- Keeps one exponentially decaying synaptic current per neuron and serializes the updated currents (index, value) toward the current input of a downstream population.
- Fixed-point format matches the neuron core: signed 32-bit, scaling 1024 (FRAC_BITS=10).

Parameters:
- NUM_NEURONS, 128, entries per sweep; index width 7.
- TAU_SHIFT, 3, decay per frame = s >>> TAU_SHIFT (tau ≈ 8 frames).
- I_MAX, 102400, symmetric saturation bound (100.0 at scale 1024).
- I_BIAS, 0, constant signed offset added to every output current.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_bar  in  1  asynchronous, active-low reset.
- population  in  128  spike vector; bit k = neuron k fired this frame.
- pop_valid  in  1  one-cycle pulse; population is valid in the same cycle.
- weight  in  32  signed synaptic weight (scale 1024); sampled at sweep start.
- I_out  out  32  signed current for neuron I_index.
- I_index  out  7  neuron index of I_out.
- I_valid  out  1  one-cycle strobe; I_out and I_index are valid in that cycle.
- sweep_done  out  1  one-cycle pulse after index 127 is emitted.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky; a frame was dropped.

Behaviour:
- Reset (reset_bar=0, asynchronous):
  - all 128 synaptic states cleared to 0;
  - I_out=0, I_index=0, I_valid=0, sweep_done=0, busy=0, overrun=0;
  - pending flag and shadow registers cleared;
  - FSM forced to IDLE.
  - Reset mid-sweep aborts the sweep with no further strobes.
- FSM states IDLE, READ, UPDATE, DONE.
  - IDLE: on pop_valid, latch population into the shadow vector, latch weight, set idx=0, go to READ.
  - READ: fetch s[idx] (registered array or RAM read); go to UPDATE.
  - UPDATE:
    - compute s_new and write it back to s[idx];
    - register I_out = sat(s_new + I_BIAS), I_index = idx, I_valid=1;
    - if idx==127 go to DONE, else idx+1 and go to READ.
  - DONE:
    - sweep_done=1 for one cycle;
    - if a frame is pending, load it and go to READ;
    - otherwise go to IDLE.
- Timing: 2 cycles per neuron, matching the neuron core's read/write cadence.
  - pop_valid at cycle t gives the first I_valid at t+2 and index k at t+2+2k.
  - sweep_done at t+257.
  - busy is high from t+1 through t+257 inclusive.
- Update arithmetic:
  - d = s >>> TAU_SHIFT (arithmetic shift).
  - s_dec = (d==0) ? 0 : s - d. This removes the positive residual stall; negative values decay to 0 naturally.
  - s_new = sat(s_dec + (shadow[idx] ? weight : 0)).
  - sat clamps to [-I_MAX, +I_MAX].
  - Intermediate sums use 33 bits so overflow cannot wrap before clamping.
- Frame arriving while busy:
  - First extra pop_valid: store the vector and weight in a one-deep pending buffer, set the pending flag.
  - Another pop_valid while pending: overwrite the pending buffer with the newer frame and set overrun (sticky until reset).
  - pop_valid in the same cycle as the DONE-state pending load: the new frame becomes the pending frame; no overrun.
- pop_valid in IDLE in the same cycle as reset deassertion: frame accepted.
- Weight changes during a sweep do not affect that sweep.

Decomposition:
- Shared package (neuron_pkg):
  - NUM_NEURONS, IDX_W=7, FRAC_BITS=10, I_MAX;
  - FSM state enum;
  - the signed 32-bit current type.
- One natural sub-module: syn_update. Purely combinational: s, spike bit, weight, TAU_SHIFT in; saturated s_new out. It is reused by the testbench reference model.

Test Plan:
1. Reset, weight=10240, one frame with only bit 5 set:
   - index 5 gives I_out=10240; all other indices give 0;
   - 128 strobes spaced 2 cycles apart; sweep_done at t+257.
2. Follow-up empty frames after scenario 1:
   - neuron 5 reads 8960, then 7840, then 6860 (s − s>>>3 each frame);
   - after enough frames it reaches exactly 0, never stalling at 1..7.
3. weight=20480, bit 0 set every frame:
   - sequence 20480, 38400, 54080, …;
   - clamps at 102400 and stays there.
4. weight=-20480 repeated on bit 127:
   - clamps at -102400;
   - with I_BIAS=1024 the output is -101376, and the output clamp holds at the bounds.
5. Two pop_valid pulses during one sweep:
   - exactly one follow-on sweep uses the second (latest) frame;
   - overrun=1 and stays set until reset_bar pulses low.
6. Assert reset_bar low at index 60 mid-sweep:
   - outputs are 0 immediately (asynchronous);
   - after release, a frame with all bits set at weight=1024 gives 1024 on every index, proving the state was cleared.
